// File: rtl/yd_mem_resp.sv
// Yduck bus responder: unified RAM on the instruction and data buses plus an MMIO page
// (GPIO, compare timer, debug-output FIFO with valid/ready port).
// Optional feature macro: YD_DBGFIFO_EN enables the debug FIFO, DBG_TX and STATUS b1..b3.
module yd_mem_resp #(
    parameter int unsigned DW        = 16,
    parameter int unsigned AW        = 16,
    parameter int unsigned RAM_AW    = 10,
    parameter int unsigned DBG_DEPTH = 4,
    parameter string       INIT_FILE = ""
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_dout,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_din,
    input  logic          d_we,
    output logic [DW-1:0] d_dout,
    input  logic [DW-1:0] gpio_in,
    output logic [DW-1:0] gpio_out,
    output logic [DW-1:0] dbg_data,
    output logic          dbg_valid,
    input  logic          dbg_ready
);

    localparam int unsigned RamWords = 1 << RAM_AW;

    localparam logic [AW-1:0] AddrGpioOut = {{(AW-8){1'b1}}, 8'h00};
    localparam logic [AW-1:0] AddrGpioIn  = {{(AW-8){1'b1}}, 8'h01};
    localparam logic [AW-1:0] AddrTimer   = {{(AW-8){1'b1}}, 8'h02};
    localparam logic [AW-1:0] AddrCmp     = {{(AW-8){1'b1}}, 8'h03};
    localparam logic [AW-1:0] AddrStatus  = {{(AW-8){1'b1}}, 8'h04};
    localparam logic [AW-1:0] AddrDbgTx   = {{(AW-8){1'b1}}, 8'h05};

    logic [DW-1:0] mem [RamWords];

    logic              i_in_ram, d_in_ram;
    logic [RAM_AW-1:0] i_idx, d_idx;
    logic              wr_gpio, wr_timer, wr_cmp, wr_status;
    logic [DW-1:0]     gpio_s1_q, gpio_s2_q;
    logic [DW-1:0]     timer_q, cmp_q;
    logic              match_q, hit;
    logic [2:0]        status_hi;
    logic [DW-1:0]     status, d_rdata;

    assign i_in_ram  = (i_addr[AW-1:RAM_AW] == '0);
    assign d_in_ram  = (d_addr[AW-1:RAM_AW] == '0);
    assign i_idx     = i_addr[RAM_AW-1:0];
    assign d_idx     = d_addr[RAM_AW-1:0];
    assign wr_gpio   = d_we && (d_addr == AddrGpioOut);
    assign wr_timer  = d_we && (d_addr == AddrTimer);
    assign wr_cmp    = d_we && (d_addr == AddrCmp);
    assign wr_status = d_we && (d_addr == AddrStatus);
    assign hit       = (timer_q == cmp_q);

`ifdef YD_DBGFIFO_EN
    localparam int unsigned PW = $clog2(DBG_DEPTH);

    logic [DW-1:0] fifo_mem [DBG_DEPTH];
    logic [PW:0]   wptr_q, rptr_q;
    logic          fifo_full, fifo_empty, push_req, push, pop, ovf_q;

    // Extra wrap bit: equal pointers mean empty, differing only in the wrap bit mean full.
    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    assign pop        = !fifo_empty && dbg_ready;
    assign push_req   = d_we && (d_addr == AddrDbgTx);
    assign push       = push_req && (!fifo_full || pop);
    assign dbg_valid  = !fifo_empty;
    assign dbg_data   = fifo_mem[rptr_q[PW-1:0]];
    assign status_hi  = {ovf_q, fifo_empty, fifo_full};

    // FIFO pointers and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            ovf_q <= (push_req && fifo_full && !pop) || (ovf_q && !(wr_status && d_din[3]));
        end
    end

    // FIFO storage, not reset.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wptr_q[PW-1:0]] <= d_din;
    end
`else
    logic unused_dbg_ready;

    assign unused_dbg_ready = dbg_ready;
    assign dbg_valid        = 1'b0;
    assign dbg_data         = '0;
    assign status_hi        = 3'b000;
`endif

    // STATUS view: b0 match, b1 full, b2 empty, b3 overflow.
    always_comb begin
        status      = '0;
        status[0]   = match_q;
        status[3:1] = status_hi;
    end

    // Data-port read mux; registers are seen with their pre-edge value (read-first).
    always_comb begin
        d_rdata = '0;
        if (d_in_ram) begin
            d_rdata = mem[d_idx];
        end else begin
            case (d_addr)
                AddrGpioOut: d_rdata = gpio_out;
                AddrGpioIn:  d_rdata = gpio_s2_q;
                AddrTimer:   d_rdata = timer_q;
                AddrCmp:     d_rdata = cmp_q;
                AddrStatus:  d_rdata = status;
                default:     d_rdata = '0;
            endcase
        end
    end

    // RAM write port, contents are not reset.
    always_ff @(posedge clk) begin
        if (d_we && d_in_ram) mem[d_idx] <= d_din;
    end

    // Registered read data for both buses; out-of-range fetch returns the 0x0000 bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_dout <= '0;
            d_dout <= '0;
        end else begin
            i_dout <= i_in_ram ? mem[i_idx] : '0;
            d_dout <= d_rdata;
        end
    end

    // GPIO, 2-flop input synchronizer, compare timer and match flag (set beats clear).
    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_out  <= '0;
            gpio_s1_q <= '0;
            gpio_s2_q <= '0;
            timer_q   <= '0;
            cmp_q     <= '0;
            match_q   <= 1'b0;
        end else begin
            gpio_s1_q <= gpio_in;
            gpio_s2_q <= gpio_s1_q;
            if (wr_gpio) gpio_out <= d_din;
            if (wr_cmp)  cmp_q    <= d_din;
            if (wr_timer)  timer_q <= d_din;
            else if (hit)  timer_q <= '0;
            else           timer_q <= timer_q + 1'b1;
            match_q <= hit || (match_q && !(wr_status && d_din[0]));
        end
    end

endmodule

// File: tb/tb_yd_mem_resp.sv
// Self-checking bench for yd_mem_resp: directed scenarios followed by random traffic, every
// cycle compared against a transaction-level reference model (arrays and a queue).
module tb_yd_mem_resp;

`ifdef YD_DBGFIFO_EN
    localparam bit FifoEn = 1'b1;
`else
    localparam bit FifoEn = 1'b0;
`endif
    localparam int Depth = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] i_addr, i_dout, d_addr, d_din, d_dout, gpio_in, gpio_out, dbg_data;
    logic        d_we, dbg_valid, dbg_ready;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [15:0] m_ram [1024];
    logic [15:0] m_gpo, m_timer, m_cmp, m_g1, m_g2;
    bit          m_match, m_ovf;
    logic [15:0] m_q [$];

    yd_mem_resp dut (
        .clk       (clk),
        .rst       (rst),
        .i_addr    (i_addr),
        .i_dout    (i_dout),
        .d_addr    (d_addr),
        .d_din     (d_din),
        .d_we      (d_we),
        .d_dout    (d_dout),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .dbg_data  (dbg_data),
        .dbg_valid (dbg_valid),
        .dbg_ready (dbg_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] m_read(input logic [15:0] a);
        logic [15:0] st;
        st = {15'b0, m_match};
        if (FifoEn) st[3:1] = {m_ovf, m_q.size() == 0, m_q.size() == Depth};
        if (a < 16'd1024) return m_ram[a[9:0]];
        case (a)
            16'hFF00: return m_gpo;
            16'hFF01: return m_g2;
            16'hFF02: return m_timer;
            16'hFF03: return m_cmp;
            16'hFF04: return st;
            default:  return 16'h0000;
        endcase
    endfunction

    // Advance the model by one clock with the current inputs, then compare all outputs.
    task automatic step();
        logic [15:0] ei, ed;
        bit hit, clr0, clr3, pop, push, ovf_set;
        ei = (i_addr < 16'd1024) ? m_ram[i_addr[9:0]] : 16'h0000;
        ed = m_read(d_addr);
        if (rst) begin
            ei = 0; ed = 0;
            m_gpo = 0; m_timer = 0; m_cmp = 0; m_match = 0; m_ovf = 0;
            m_g1 = 0; m_g2 = 0;
            m_q.delete();
        end else begin
            hit  = (m_timer == m_cmp);
            clr0 = d_we && d_addr == 16'hFF04 && d_din[0];
            clr3 = d_we && d_addr == 16'hFF04 && d_din[3];
            if (d_we && d_addr < 16'd1024) m_ram[d_addr[9:0]] = d_din;
            if (d_we && d_addr == 16'hFF02) m_timer = d_din;
            else if (hit) m_timer = 0;
            else m_timer = m_timer + 16'd1;
            if (d_we && d_addr == 16'hFF03) m_cmp = d_din;
            if (d_we && d_addr == 16'hFF00) m_gpo = d_din;
            m_match = hit || (m_match && !clr0);
            pop  = (m_q.size() > 0) && dbg_ready;
            push = FifoEn && d_we && d_addr == 16'hFF05;
            ovf_set = 0;
            if (pop) void'(m_q.pop_front());
            if (push) begin
                if (m_q.size() < Depth) m_q.push_back(d_din);
                else ovf_set = 1;
            end
            m_ovf = ovf_set || (m_ovf && !clr3);
            m_g2 = m_g1;
            m_g1 = gpio_in;
        end
        @(posedge clk);
        #1;
        chk("i_dout", i_dout, ei);
        chk("d_dout", d_dout, ed);
        chk("gpio_out", gpio_out, m_gpo);
        chk("dbg_valid", {15'b0, dbg_valid}, {15'b0, m_q.size() > 0});
        if (m_q.size() > 0) chk("dbg_data", dbg_data, m_q[0]);
`ifndef YD_DBGFIFO_EN
        chk("dbg_data_off", dbg_data, 16'h0000);
`endif
    endtask

    task automatic drv(input logic we, input logic [15:0] a, input logic [15:0] din,
                       input logic [15:0] ia);
        d_we = we; d_addr = a; d_din = din; i_addr = ia;
        step();
    endtask

    initial begin
        rst = 1; d_we = 0; d_addr = 0; d_din = 0; i_addr = 0; gpio_in = 0; dbg_ready = 0;
        m_gpo = 0; m_timer = 0; m_cmp = 0; m_g1 = 0; m_g2 = 0; m_match = 0; m_ovf = 0;
        #1;
        step();
        step();
        chk("rst_d_dout", d_dout, 16'h0000);
        chk("rst_i_dout", i_dout, 16'h0000);
        rst = 0;

        // Fill the RAM window used by the bench so every later read is defined
        for (int a = 0; a < 64; a++) drv(1, 16'(a), 16'($urandom), 16'(a));

        // T1: write then read on both ports, unmapped read
        drv(1, 16'h0010, 16'h1234, 16'h0000);
        drv(0, 16'h0010, 16'h0000, 16'h0010);
        chk("t1_d", d_dout, 16'h1234);
        chk("t1_i", i_dout, 16'h1234);
        drv(0, 16'h8000, 16'h0000, 16'h8000);
        chk("t1_unmapped_d", d_dout, 16'h0000);
        chk("t1_unmapped_i", i_dout, 16'h0000);

        // T2: read-during-write returns old data
        drv(1, 16'h0020, 16'h1111, 16'h0000);
        drv(1, 16'h0020, 16'hBEEF, 16'h0020);
        chk("t2_old_d", d_dout, 16'h1111);
        chk("t2_old_i", i_dout, 16'h1111);
        drv(0, 16'h0020, 16'h0000, 16'h0020);
        chk("t2_new_d", d_dout, 16'hBEEF);

        // T3: compare timer, W1C of match loses against a same-cycle match
        drv(1, 16'hFF03, 16'h0005, 16'h0000);
        drv(1, 16'hFF02, 16'h0000, 16'h0000);
        drv(1, 16'hFF04, 16'h0009, 16'h0000);
        drv(0, 16'hFF04, 16'h0000, 16'h0000);
        chk("t3_match_clear", {15'b0, d_dout[0]}, 16'h0000);
        drv(0, 16'h0000, 16'h0000, 16'h0000);
        drv(0, 16'h0000, 16'h0000, 16'h0000);
        drv(0, 16'h0000, 16'h0000, 16'h0000);
        drv(1, 16'hFF04, 16'h0001, 16'h0000);
        drv(0, 16'hFF02, 16'h0000, 16'h0000);
        chk("t3_timer_wrap", d_dout, 16'h0000);
        drv(0, 16'hFF04, 16'h0000, 16'h0000);
        chk("t3_match_set_wins", {15'b0, d_dout[0]}, 16'h0001);

        // T4: fill past depth with sink stalled, then drain
        dbg_ready = 0;
        for (int k = 0; k < 5; k++) drv(1, 16'hFF05, 16'h00A0 + 16'(k), 16'h0000);
        drv(0, 16'hFF04, 16'h0000, 16'h0000);
`ifdef YD_DBGFIFO_EN
        chk("t4_status", {13'b0, d_dout[3:1]}, 16'h0005);
        chk("t4_head", dbg_data, 16'h00A0);
        dbg_ready = 1;
        for (int k = 1; k < 4; k++) begin
            drv(0, 16'h0000, 16'h0000, 16'h0000);
            chk("t4_order", dbg_data, 16'h00A0 + 16'(k));
        end
        drv(0, 16'h0000, 16'h0000, 16'h0000);
        chk("t4_drained", {15'b0, dbg_valid}, 16'h0000);
`else
        chk("t4_status_off", {13'b0, d_dout[3:1]}, 16'h0000);
        chk("t4_valid_off", {15'b0, dbg_valid}, 16'h0000);
`endif
        drv(1, 16'hFF04, 16'h0008, 16'h0000);

        // T5: push into a full FIFO while popping is accepted
        dbg_ready = 0;
        for (int k = 1; k < 5; k++) drv(1, 16'hFF05, 16'h00C0 + 16'(k), 16'h0000);
        dbg_ready = 1;
        drv(1, 16'hFF05, 16'h00C5, 16'h0000);
        drv(0, 16'hFF04, 16'h0000, 16'h0000);
        chk("t5_no_overflow", {15'b0, d_dout[3]}, 16'h0000);
`ifdef YD_DBGFIFO_EN
        chk("t5_order_c3", dbg_data, 16'h00C3);
        drv(0, 16'h0000, 16'h0000, 16'h0000);
        chk("t5_order_c4", dbg_data, 16'h00C4);
        drv(0, 16'h0000, 16'h0000, 16'h0000);
        chk("t5_order_c5", dbg_data, 16'h00C5);
`endif
        drv(0, 16'h0000, 16'h0000, 16'h0000);

        // T6: GPIO synchronizer latency, then reset in the middle of traffic
        gpio_in = 16'h00FF;
        drv(0, 16'h0000, 16'h0000, 16'h0000);
        drv(0, 16'h0000, 16'h0000, 16'h0000);
        drv(0, 16'hFF01, 16'h0000, 16'h0000);
        chk("t6_gpio_in", d_dout, 16'h00FF);
        drv(1, 16'hFF00, 16'h5A5A, 16'h0000);
        dbg_ready = 0;
        drv(1, 16'hFF05, 16'h0077, 16'h0000);
        rst = 1;
        drv(0, 16'h0000, 16'h0000, 16'h0000);
        chk("t6_rst_gpio_out", gpio_out, 16'h0000);
        chk("t6_rst_valid", {15'b0, dbg_valid}, 16'h0000);
        rst = 0;
        drv(0, 16'hFF02, 16'h0000, 16'h0000);
        chk("t6_rst_timer", d_dout, 16'h0000);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [15:0] a, ia;
            logic        we;
            int          sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 5)      a = 16'($urandom_range(0, 63));
            else if (sel < 9) a = 16'hFF00 + 16'($urandom_range(0, 7));
            else              a = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
            ia = ($urandom_range(0, 3) == 0) ? (16'h0400 | 16'($urandom)) :
                                               16'($urandom_range(0, 63));
            we = 1'($urandom);
            rst = ($urandom_range(0, 99) == 0);
            if (rst) we = 0;
            dbg_ready = 1'($urandom);
            if ($urandom_range(0, 3) == 0) gpio_in = 16'($urandom);
            drv(we, a, 16'($urandom), ia);
        end
        rst = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
